// File: rtl/axi_write_slave.sv
// AXI4 write slave with an internal DW-bit word memory and a combinational backdoor read port.
// Optional macro AXI_WSLV_WRAP_EN enables WRAP bursts; without it WRAP is answered with SLVERR.
module axi_write_slave #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int MEM_WORDS = 256,
    localparam int IW       = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [2:0]      axi_awsize,
    input  logic [1:0]      axi_awburst,
    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [DW-1:0]   axi_wdata,
    input  logic [DW/8-1:0] axi_wstrb,
    input  logic            axi_wlast,
    input  logic            axi_wvalid,
    output logic            axi_wready,
    output logic [1:0]      axi_bresp,
    output logic            axi_bvalid,
    input  logic            axi_bready,
    input  logic [IW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_rdata
);

`ifdef AXI_WSLV_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic            r_err;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic [DW-1:0]   r_mem [MEM_WORDS];

    logic [AW-1:0]   w_step;
    logic [AW-1:0]   w_inc;
    logic [AW-1:0]   w_mask;
    logic [AW-1:0]   w_byte;
    logic [AW-1:0]   w_word;
    logic            w_wrap_len_ok;
    logic            w_beat_err;
    logic            w_at_len;
    logic            w_last_beat;
    logic            w_last_err;
    logic            w_whs;
    logic            w_we;

    // Beat address: offset grows by one beat size per accepted beat; WRAP folds it
    // back into the aligned window of (len+1)<<size bytes.
    assign w_step = AW'(r_cnt) << r_size;
    assign w_inc  = r_addr + w_step;
    assign w_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);

    always_comb begin
        w_byte = r_addr;
        case (r_burst)
            2'b00:   w_byte = r_addr;
            2'b01:   w_byte = w_inc;
            default: w_byte = (r_addr & ~w_mask) | (w_inc & w_mask);
        endcase
    end

    assign w_word        = w_byte >> 3;
    assign w_wrap_len_ok = r_len inside {8'd1, 8'd3, 8'd7, 8'd15};
    assign w_beat_err    = (r_size > 3'd3) || (r_burst == 2'b11)
                         || ((r_burst == 2'b10) && (!WRAP_EN || !w_wrap_len_ok))
                         || (w_word >= AW'(MEM_WORDS));
    assign w_at_len      = (r_cnt == r_len);
    assign w_last_beat   = axi_wlast || w_at_len;
    assign w_last_err    = axi_wlast != w_at_len;
    assign w_whs         = axi_wvalid && r_wready;
    assign w_we          = w_whs && !w_beat_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_awready <= 1'b1;
                    if (axi_awvalid && r_awready) begin
                        r_addr    <= axi_awaddr;
                        r_len     <= axi_awlen;
                        r_size    <= axi_awsize;
                        r_burst   <= axi_awburst;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_whs) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_beat_err || w_last_err) r_err <= 1'b1;
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_err || w_beat_err || w_last_err) ? 2'b10 : 2'b00;
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (axi_bready && r_bvalid) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so completed beats survive a reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (axi_wstrb[b]) r_mem[w_word[IW-1:0]][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    assign dbg_rdata   = r_mem[dbg_addr];
    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_write_slave.sv
// Scenario bench for axi_write_slave: expected B responses are queued as bursts are
// issued and popped when the slave answers; memory is compared against a 16-word model.
module tb_axi_write_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic [2:0]  axi_awsize = '0;
    logic [1:0]  axi_awburst = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [63:0] axi_wdata = '0;
    logic [7:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [63:0] dbg_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  q_resp[$];
    logic [63:0] m_mem [16];

    axi_write_slave dut (
        .clk(clk), .reset(reset),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Drivers are entered and left 1ns after a rising edge.
    task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output bit ok);
        axi_awaddr = a; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi_awready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input bit last, output bit ok);
        axi_wdata = d; axi_wstrb = s; axi_wlast = last; axi_wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi_wready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        resp = 2'bxx;
        for (int i = 0; i < 50; i++) begin
            if (axi_bvalid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            resp = axi_bresp;
            axi_bready = 1'b1;
            @(posedge clk); #1;
            axi_bready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_bresp} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b resp=%b, expected all 0",
                     axi_awready, axi_wready, axi_bvalid, axi_bresp);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (axi_awready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_awready: got %b expected 1", axi_awready);
        end
    endtask

    task automatic test_fill();
        bit ok, okw; logic [1:0] r;
        q_resp.push_back(2'b00);
        send_aw(32'h0, 8'd15, 3'd3, 2'b01, ok);
        okw = ok;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = {32'hF111_0000, 32'(i)};
            send_w(m_mem[i], 8'hFF, i == 15, ok);
            okw &= ok;
        end
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL fill_bresp: got %b (handshakes %b) expected 00", r, ok && okw);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL fill_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_incr();
        bit ok, okw; logic [1:0] r;
        q_resp.push_back(2'b00);
        send_aw(32'h10, 8'd3, 3'd3, 2'b01, ok);
        okw = ok;
        for (int i = 0; i < 4; i++) begin
            m_mem[2+i] = 64'hA0 + 64'(i);
            send_w(m_mem[2+i], 8'hFF, i == 3, ok);
            okw &= ok;
        end
        n_checks++;
        if (axi_bvalid !== 1'b1) begin
            n_errors++; $display("FAIL incr_bvalid_latency: got %b expected 1 one cycle after last beat", axi_bvalid);
        end
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL incr_bresp: got %b expected 00", r);
        end
        n_checks++;
        if (axi_awready !== 1'b1) begin
            n_errors++; $display("FAIL incr_awready_after_b: got %b expected 1", axi_awready);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL incr_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_strobe_fixed();
        bit ok, okw; logic [1:0] r;
        q_resp.push_back(2'b00);
        send_aw(32'h08, 8'd1, 3'd3, 2'b00, ok);
        okw = ok;
        send_w(64'h1111111111111111, 8'h0F, 1'b0, ok); okw &= ok;
        send_w(64'h2222222222222222, 8'hF0, 1'b1, ok); okw &= ok;
        m_mem[1] = 64'h2222222211111111;
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL fixed_bresp: got %b expected 00", r);
        end
        // All-zero strobe: nothing written, still OKAY.
        q_resp.push_back(2'b00);
        send_aw(32'h30, 8'd0, 3'd3, 2'b01, ok); okw = ok;
        send_w(64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b1, ok); okw &= ok;
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL zero_strobe_bresp: got %b expected 00", r);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL strobe_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_early_wlast();
        bit ok, okw; logic [1:0] r;
        q_resp.push_back(2'b10);
        send_aw(32'h30, 8'd3, 3'd3, 2'b01, ok); okw = ok;
        send_w(64'hD0, 8'hFF, 1'b0, ok); okw &= ok;
        send_w(64'hD1, 8'hFF, 1'b1, ok); okw &= ok;
        m_mem[6] = 64'hD0;
        m_mem[7] = 64'hD1;
        n_checks++;
        if (axi_wready !== 1'b0 || axi_bvalid !== 1'b1) begin
            n_errors++; $display("FAIL early_wlast_end: got wready=%b bvalid=%b expected 0/1", axi_wready, axi_bvalid);
        end
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL early_wlast_bresp: got %b expected 10", r);
        end
        // Missing wlast on the final beat is also an error.
        q_resp.push_back(2'b10);
        send_aw(32'h50, 8'd0, 3'd3, 2'b01, ok); okw = ok;
        send_w(64'hD2, 8'hFF, 1'b0, ok); okw &= ok;
        m_mem[10] = 64'hD2;
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL missing_wlast_bresp: got %b expected 10", r);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL wlast_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        bit ok, okw; logic [1:0] r;
        logic [31:0] addr[3]  = '{32'd2048, 32'h0, 32'h0};
        logic [2:0]  size[3]  = '{3'd3, 3'd4, 3'd3};
        logic [1:0]  burst[3] = '{2'b01, 2'b01, 2'b11};
        for (int t = 0; t < 3; t++) begin
            q_resp.push_back(2'b10);
            send_aw(addr[t], 8'd0, size[t], burst[t], ok); okw = ok;
            send_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1, ok); okw &= ok;
            n_checks++;
            if (!okw || axi_bvalid !== 1'b1) begin
                n_errors++; $display("FAIL err%0d_bvalid: got %b expected 1", t, axi_bvalid);
            end
            // Response must hold steady while the master stalls.
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                n_checks++;
                if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b10) begin
                    n_errors++; $display("FAIL err%0d_stall%0d: got bvalid=%b bresp=%b expected 1/10", t, c, axi_bvalid, axi_bresp);
                end
            end
            get_b(r, ok);
            n_checks++;
            if (!ok || r !== q_resp.pop_front()) begin
                n_errors++; $display("FAIL err%0d_bresp: got %b expected 10", t, r);
            end
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL err_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        bit ok, okw; logic [1:0] r;
        int order[4] = '{3, 0, 1, 2};
`ifdef AXI_WSLV_WRAP_EN
        q_resp.push_back(2'b00);
`else
        q_resp.push_back(2'b10);
`endif
        send_aw(32'h18, 8'd3, 3'd3, 2'b10, ok); okw = ok;
        for (int i = 0; i < 4; i++) begin
            send_w(64'hC0 + 64'(i), 8'hFF, i == 3, ok); okw &= ok;
`ifdef AXI_WSLV_WRAP_EN
            m_mem[order[i]] = 64'hC0 + 64'(i);
`endif
        end
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL wrap_bresp: got %b (order %0d..)", r, order[0]);
        end
        // WRAP with an illegal length (3 beats) is always rejected.
        q_resp.push_back(2'b10);
        send_aw(32'h40, 8'd2, 3'd3, 2'b10, ok); okw = ok;
        for (int i = 0; i < 3; i++) begin
            send_w(64'hEE, 8'hFF, i == 2, ok); okw &= ok;
        end
        get_b(r, ok);
        n_checks++;
        if (!(ok && okw) || r !== q_resp.pop_front()) begin
            n_errors++; $display("FAIL wrap_badlen_bresp: got %b expected 10", r);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL wrap_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok, okw; logic [1:0] r;
        for (int t = 0; t < 2; t++) begin
            q_resp.push_back(2'b00);
            send_aw(32'h60 + 32'(t*8), 8'd0, 3'd3, 2'b01, ok); okw = ok;
            send_w(64'hB0 + 64'(t), 8'hFF, 1'b1, ok); okw &= ok;
            m_mem[12+t] = 64'hB0 + 64'(t);
            get_b(r, ok);
            n_checks++;
            if (!(ok && okw) || r !== q_resp.pop_front()) begin
                n_errors++; $display("FAIL b2b%0d_bresp: got %b expected 00", t, r);
            end
        end
        for (int i = 12; i < 14; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        bit ok, okw;
        send_aw(32'h40, 8'd3, 3'd3, 2'b01, ok); okw = ok;
        send_w(64'hE0, 8'hFF, 1'b0, ok); okw &= ok;
        m_mem[8] = 64'hE0;
        axi_wdata = 64'hE1; axi_wstrb = 8'hFF; axi_wvalid = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (!okw || {axi_awready, axi_wready, axi_bvalid} !== 3'b000) begin
            n_errors++; $display("FAIL midreset_outputs: got aw=%b w=%b b=%b expected 000",
                                 axi_awready, axi_wready, axi_bvalid);
        end
        axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (axi_awready !== 1'b1) begin
            n_errors++; $display("FAIL midreset_awready: got %b expected 1", axi_awready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (axi_bvalid !== 1'b0) begin
                n_errors++; $display("FAIL midreset_bvalid%0d: got %b expected 0", c, axi_bvalid);
            end
        end
        for (int i = 8; i < 10; i++) begin
            dbg_addr = 8'(i); #1;
            n_checks++;
            if (dbg_rdata !== m_mem[i]) begin
                n_errors++; $display("FAIL midreset_mem[%0d]: got %h expected %h", i, dbg_rdata, m_mem[i]);
            end
        end
        n_checks++;
        if (q_resp.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", q_resp.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_incr();
        test_strobe_fixed();
        test_early_wlast();
        test_errors();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
